// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: a - b - bin, LSB first, one bit per clock.
// One full-subtractor stage feeds a registered borrow; results land
// in output registers only on the final bit, so partial sums never show.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_sh_q, r_sh_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic a0, b0, d_bit, br_nxt, last;

  // Single full-subtractor bit stage on the current LSBs
  assign a0     = a_sh_q[0];
  assign b0     = b_sh_q[0];
  assign d_bit  = a0 ^ b0 ^ br_q;
  assign br_nxt = (~a0 & b0) | (~(a0 ^ b0) & br_q);
  assign last   = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      r_sh_q   <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      r_sh_q   <= r_sh_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  // Next-state: start is only looked at in IDLE, so it is ignored while busy
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture on accept, shift one bit per cycle, publish on last bit
  always_comb begin
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    r_sh_d   = r_sh_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        a_sh_d = a;
        b_sh_d = b;
        br_d   = bin;
        cnt_d  = '0;
        r_sh_d = '0;
      end
    end else begin
      a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
      b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
      r_sh_d = {d_bit, r_sh_q[WIDTH-1:1]};
      br_d   = br_nxt;
      cnt_d  = cnt_q + CW'(1);
      if (last) begin
        // On the last bit a0/b0/d_bit are the MSBs: sign-rule overflow
        diff_d   = {d_bit, r_sh_q[WIDTH-1:1]};
        borrow_d = br_nxt;
        ovf_d    = (a0 != b0) && (d_bit != a0);
        done_d   = 1'b1;
      end
    end
  end

  // Outputs: busy decoded from state, results straight from registers
  always_comb begin
    busy       = (state_q == SHIFT);
    done       = done_q;
    diff       = diff_q;
    borrow_out = borrow_q;
    ovf        = ovf_q;
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed vectors,
// randomized operands against an arithmetic model, handshake timing,
// start-while-busy, back-to-back and mid-operation reset.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk, rst_n, start, bin;
  logic [W-1:0] a, b;
  logic         busy, done, borrow_out, ovf;
  logic [W-1:0] diff;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, sign rule for overflow
  function automatic void model(input logic [W-1:0] ia, ib, input logic ibin,
                                output logic [W-1:0] ed, output logic eb, output logic eo);
    int r;
    r  = int'(ia) - int'(ib) - int'(ibin);
    ed = W'(r);
    eb = (r < 0);
    eo = (ia[W-1] != ib[W-1]) && (ed[W-1] != ia[W-1]);
  endfunction

  // Drive one operation; returns at the negedge inside the done cycle.
  // b2b: already in a done cycle, so assert start without waiting.
  // disturb: scramble inputs and start while busy.
  task automatic run_op(input logic [W-1:0] ia, ib, input logic ibin,
                        input bit b2b, input bit disturb,
                        output int nbusy, output int ncyc, output bit tmo);
    if (!b2b) @(negedge clk);
    a = ia; b = ib; bin = ibin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nbusy = 0; ncyc = 1; tmo = 1'b1;
    for (int i = 0; i < 3 * W; i++) begin
      if (done) begin tmo = 1'b0; break; end
      if (busy) nbusy++;
      if (disturb) begin
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom); start = 1'($urandom);
      end
      @(negedge clk);
      ncyc++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, diff, borrow_out, ovf} !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b diff=%h bo=%b ovf=%b, want all 0",
               busy, done, diff, borrow_out, ovf);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_directed;
    logic [W-1:0] va [5] = '{8'h35, 8'h00, 8'h80, 8'h10, 8'h00};
    logic [W-1:0] vb [5] = '{8'h12, 8'h01, 8'h01, 8'h0F, 8'h00};
    logic         vc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] xd [5] = '{8'h23, 8'hFF, 8'h7F, 8'h00, 8'hFF};
    logic         xb [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic         xo [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int nb, nc; bit t;
    for (int k = 0; k < 5; k++) begin
      run_op(va[k], vb[k], vc[k], 1'b0, 1'b0, nb, nc, t);
      checks++;
      if (t || nb != W || nc != W + 1) begin
        errors++;
        $display("FAIL directed%0d_timing: timeout=%0b busy_cycles=%0d edges=%0d, want 0 %0d %0d",
                 k, t, nb, nc, W, W + 1);
      end
      checks++;
      if (diff !== xd[k] || borrow_out !== xb[k] || ovf !== xo[k]) begin
        errors++;
        $display("FAIL directed%0d_result: got diff=%h bo=%b ovf=%b, want %h %b %b",
                 k, diff, borrow_out, ovf, xd[k], xb[k], xo[k]);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || diff !== xd[k]) begin
        errors++;
        $display("FAIL directed%0d_pulse_hold: done=%b diff=%h, want 0 %h", k, done, diff, xd[k]);
      end
    end
  endtask

  task automatic test_random;
    logic [W-1:0] ra, rb, ed; logic rc, eb, eo;
    int nb, nc; bit t, chain;
    chain = 1'b0;
    for (int k = 0; k < 40; k++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      if (k % 8 == 0) ra = '0;
      if (k % 8 == 1) rb = '1;
      model(ra, rb, rc, ed, eb, eo);
      run_op(ra, rb, rc, chain, 1'b0, nb, nc, t);
      checks++;
      if (t || nc != W + 1 || diff !== ed || borrow_out !== eb || ovf !== eo) begin
        errors++;
        $display("FAIL random%0d: a=%h b=%h bin=%b got diff=%h bo=%b ovf=%b edges=%0d, want %h %b %b %0d",
                 k, ra, rb, rc, diff, borrow_out, ovf, nc, ed, eb, eo, W + 1);
      end
      chain = 1'($urandom);
    end
    @(negedge clk);
  endtask

  task automatic test_busy_ignore;
    logic [W-1:0] ed; logic eb, eo;
    int nb, nc; bit t;
    model(8'hA7, 8'h3C, 1'b1, ed, eb, eo);
    run_op(8'hA7, 8'h3C, 1'b1, 1'b0, 1'b1, nb, nc, t);
    checks++;
    if (t || nb != W || diff !== ed || borrow_out !== eb || ovf !== eo) begin
      errors++;
      $display("FAIL busy_ignore: got diff=%h bo=%b ovf=%b busy=%0d, want %h %b %b %0d",
               diff, borrow_out, ovf, nb, ed, eb, eo, W);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] ed; logic eb, eo;
    int nb, nc; bit t;
    model(8'h5A, 8'hC3, 1'b0, ed, eb, eo);
    run_op(8'h5A, 8'hC3, 1'b0, 1'b1, 1'b0, nb, nc, t);
    checks++;
    if (t || nb != W || nc != W + 1 || diff !== ed || borrow_out !== eb || ovf !== eo) begin
      errors++;
      $display("FAIL back_to_back: got diff=%h bo=%b ovf=%b edges=%0d, want %h %b %b %0d",
               diff, borrow_out, ovf, nc, ed, eb, eo, W + 1);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int nb, nc, seen; bit t;
    run_op(8'h80, 8'h01, 1'b0, 1'b0, 1'b0, nb, nc, t);
    @(negedge clk);
    a = 8'hC4; b = 8'h2B; bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, diff, borrow_out, ovf} !== '0) begin
      errors++;
      $display("FAIL reset_mid_clear: busy=%b done=%b diff=%h bo=%b ovf=%b, want all 0",
               busy, done, diff, borrow_out, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_mid_quiet: %0d cycles with done/busy, want 0", seen);
    end
    run_op(8'h35, 8'h12, 1'b0, 1'b0, 1'b0, nb, nc, t);
    checks++;
    if (t || diff !== 8'h23 || borrow_out !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_rerun: timeout=%0b diff=%h bo=%b ovf=%b, want 0 23 0 0",
               t, diff, borrow_out, ovf);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
